full_adder: RTL and testbench

Binary full-adder cell with an optional output register stage. It is parameterised in width and is the arithmetic primitive used by the 4-bit BCD adder and the add/subtract paths: four WIDTH=1 instances form each ripple chain. For WIDTH>1 it computes {cout,s} = a + b + cin as an internal ripple chain. It also exposes the propagate/generate vectors and a signed-overflow flag for carry-lookahead users.

---
 rtl/full_adder_if.sv | 26 ++
 rtl/full_adder.sv | 88 ++++++++
 tb/tb_full_adder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for one full_adder instance: the master drives operands,
// the slave returns sum, carry, propagate/generate and overflow.
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic             ovf;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  s, cout, p, g, ovf, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output s, cout, p, g, ovf, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder of parameterised width with propagate/generate/overflow taps
// and an optional single output register stage.
module full_adder #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 0
) (
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic             ovf
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_ovf;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_p[gi]   = a[gi] ^ b[gi];
      assign w_g[gi]   = a[gi] & b[gi];
      assign w_s[gi]   = w_p[gi] ^ w_c[gi];
      assign w_c[gi+1] = w_g[gi] | (w_c[gi] & w_p[gi]);
    end
  endgenerate

  // Carry into the MSB versus carry out; reduces to cin ^ cout when WIDTH=1.
  assign w_ovf = w_c[WIDTH-1] ^ w_c[WIDTH];

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] r_s;
      logic             r_cout;
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_g;
      logic             r_ovf;
      logic             r_out_valid;

      // Data loads every cycle; only the valid flag qualifies it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s         <= '0;
          r_cout      <= 1'b0;
          r_p         <= '0;
          r_g         <= '0;
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b0;
        end else begin
          r_s         <= w_s;
          r_cout      <= w_c[WIDTH];
          r_p         <= w_p;
          r_g         <= w_g;
          r_ovf       <= w_ovf;
          r_out_valid <= in_valid;
        end
      end

      assign s         = r_s;
      assign cout      = r_cout;
      assign p         = r_p;
      assign g         = r_g;
      assign ovf       = r_ovf;
      assign out_valid = r_out_valid;
    end else begin : g_comb
      logic w_unused_clk_rst;

      assign w_unused_clk_rst = &{1'b0, clk, rst};
      assign s         = w_s;
      assign cout      = w_c[WIDTH];
      assign p         = w_p;
      assign g         = w_g;
      assign ovf       = w_ovf;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in combinational and registered forms,
// plus a four-cell ripple chain used as the binary stage of a BCD digit adder.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  full_adder_if #(.WIDTH(1)) if_c1 ();
  full_adder_if #(.WIDTH(4)) if_c4 ();
  full_adder_if #(.WIDTH(1)) if_r1 ();
  full_adder_if #(.WIDTH(8)) if_r8 ();

  full_adder #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .s(if_c1.s), .cout(if_c1.cout), .a(if_c1.a), .b(if_c1.b), .cin(if_c1.cin),
    .clk(clk), .rst(rst), .in_valid(if_c1.in_valid), .out_valid(if_c1.out_valid),
    .p(if_c1.p), .g(if_c1.g), .ovf(if_c1.ovf));

  full_adder #(.WIDTH(4), .REG_OUT(0)) u_c4 (
    .s(if_c4.s), .cout(if_c4.cout), .a(if_c4.a), .b(if_c4.b), .cin(if_c4.cin),
    .clk(clk), .rst(rst), .in_valid(if_c4.in_valid), .out_valid(if_c4.out_valid),
    .p(if_c4.p), .g(if_c4.g), .ovf(if_c4.ovf));

  full_adder #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .s(if_r1.s), .cout(if_r1.cout), .a(if_r1.a), .b(if_r1.b), .cin(if_r1.cin),
    .clk(clk), .rst(rst), .in_valid(if_r1.in_valid), .out_valid(if_r1.out_valid),
    .p(if_r1.p), .g(if_r1.g), .ovf(if_r1.ovf));

  full_adder #(.WIDTH(8), .REG_OUT(1)) u_r8 (
    .s(if_r8.s), .cout(if_r8.cout), .a(if_r8.a), .b(if_r8.b), .cin(if_r8.cin),
    .clk(clk), .rst(rst), .in_valid(if_r8.in_valid), .out_valid(if_r8.out_valid),
    .p(if_r8.p), .g(if_r8.g), .ovf(if_r8.ovf));

  // Four 1-bit cells rippled together: binary stage of a BCD digit adder.
  logic [3:0] bcd_a;
  logic [3:0] bcd_b;
  logic [4:0] bcd_c;
  logic [3:0] bcd_s;
  logic [3:0] bcd_unused_p;
  logic [3:0] bcd_unused_g;
  logic [3:0] bcd_unused_ovf;
  logic [3:0] bcd_unused_ov;

  assign bcd_c[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      full_adder #(.WIDTH(1), .REG_OUT(0)) u_cell (
        .s(bcd_s[gi]), .cout(bcd_c[gi+1]), .a(bcd_a[gi]), .b(bcd_b[gi]),
        .cin(bcd_c[gi]), .clk(clk), .rst(rst), .in_valid(1'b1),
        .out_valid(bcd_unused_ov[gi]), .p(bcd_unused_p[gi]), .g(bcd_unused_g[gi]),
        .ovf(bcd_unused_ovf[gi]));
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer addition, overflow from operand/result sign bits.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, output logic [31:0] es, output logic ec,
                       output logic eovf);
    logic [63:0] sum;
    logic [63:0] mask;
    logic        sa, sb, ss;
    sum  = 64'(a) + 64'(b) + 64'(ci);
    mask = (64'd1 << w) - 64'd1;
    es   = 32'(sum & mask);
    ec   = sum[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = es[w-1];
    eovf = (sa == sb) && (ss != sa);
  endtask

  task automatic run_c4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input string tag);
    logic [31:0] es;
    logic        ec, eo;
    if_c4.a = a; if_c4.b = b; if_c4.cin = ci; if_c4.in_valid = 1'b1;
    #1;
    model(4, 32'(a), 32'(b), ci, es, ec, eo);
    chk({tag, "_sum"}, {if_c4.cout, if_c4.s}, {ec, es[3:0]});
    chk({tag, "_p"},   if_c4.p, a ^ b);
    chk({tag, "_g"},   if_c4.g, a & b);
    chk({tag, "_ovf"}, if_c4.ovf, eo);
  endtask

  task automatic run_bcd(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_digit, input logic exp_carry);
    logic [4:0] bin;
    logic [4:0] corr;
    bcd_a = a; bcd_b = b;
    #1;
    bin = {bcd_c[4], bcd_s};
    chk("bcd_bin", bin, 5'(a) + 5'(b));
    corr = (bin > 5'd9) ? bin + 5'd6 : bin;
    chk("bcd_digit", {(bin > 5'd9), corr[3:0]}, {exp_carry, exp_digit});
  endtask

  task automatic r1_drive(input logic a, input logic b, input logic ci, input logic iv);
    if_r1.a = a; if_r1.b = b; if_r1.cin = ci; if_r1.in_valid = iv;
  endtask

  initial begin
    logic [31:0] es;
    logic        ec, eo;
    logic [1:0]  prev;

    if_c1.a = 0; if_c1.b = 0; if_c1.cin = 0; if_c1.in_valid = 1;
    if_c4.a = 0; if_c4.b = 0; if_c4.cin = 0; if_c4.in_valid = 1;
    r1_drive(1'b1, 1'b1, 1'b1, 1'b1);
    if_r8.a = 0; if_r8.b = 0; if_r8.cin = 0; if_r8.in_valid = 1;
    bcd_a = 0; bcd_b = 0;

    // WIDTH=1 combinational, all eight input combinations.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic       iv;
      v  = 3'(i);
      iv = 1'($urandom_range(0, 1));
      if_c1.a = v[2]; if_c1.b = v[1]; if_c1.cin = v[0]; if_c1.in_valid = iv;
      #1;
      model(1, 32'(v[2]), 32'(v[1]), v[0], es, ec, eo);
      chk("c1_sum", {if_c1.cout, if_c1.s}, {ec, es[0]});
      chk("c1_p", if_c1.p, v[2] ^ v[1]);
      chk("c1_g", if_c1.g, v[2] & v[1]);
      chk("c1_ovf", if_c1.ovf, eo);
      chk("c1_valid", if_c1.out_valid, iv);
      $display("c1 a=%0d b=%0d cin=%0d -> cout=%0d s=%0d", v[2], v[1], v[0], if_c1.cout, if_c1.s);
    end
    if_c1.a = 1; if_c1.b = 1; if_c1.cin = 1; #1;
    chk("c1_111", {if_c1.cout, if_c1.s}, 2'b11);
    if_c1.a = 1; if_c1.b = 0; if_c1.cin = 0; #1;
    chk("c1_100", {if_c1.cout, if_c1.s}, 2'b01);

    // WIDTH=4 corners with constant expectations, then random vectors.
    run_c4(4'hF, 4'h1, 1'b0, "c4_f1");
    chk("c4_f1_const", {if_c4.cout, if_c4.s}, 5'b1_0000);
    run_c4(4'h7, 4'h1, 1'b0, "c4_71");
    chk("c4_71_const", {if_c4.ovf, if_c4.cout, if_c4.s}, 6'b10_1000);
    run_c4(4'hA, 4'hE, 1'b1, "c4_ae");
    chk("c4_ae_const", {if_c4.cout, if_c4.s}, 5'b1_1001);
    for (int i = 0; i < 20; i++) begin
      run_c4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), "c4_rnd");
      $display("c4 a=%0h b=%0h cin=%0d -> cout=%0d s=%0h", if_c4.a, if_c4.b, if_c4.cin, if_c4.cout, if_c4.s);
    end

    // BCD digit adder built on four 1-bit cells.
    run_bcd(4'd1, 4'd4, 4'd5, 1'b0);
    run_bcd(4'd3, 4'd1, 4'd4, 1'b0);
    run_bcd(4'd12, 4'd2, 4'd4, 1'b1);

    // Registered: two reset cycles with a valid 1+1+1 pending, which must never appear.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("r1_rst_data", {if_r1.ovf, if_r1.g, if_r1.p, if_r1.cout, if_r1.s}, 5'b0);
      chk("r1_rst_valid", if_r1.out_valid, 1'b0);
      $display("r1 reset cycle %0d out_valid=%0d", i, if_r1.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    r1_drive(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("r1_first", {if_r1.out_valid, if_r1.cout, if_r1.s}, 3'b110);
    chk("r1_first_pgo", {if_r1.p, if_r1.g, if_r1.ovf}, 3'b011);

    // Back-to-back vectors: result appears one edge later and holds until the next edge.
    prev = 2'b10;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] v;
      logic [1:0] exp_sum;
      v = (i == 0) ? 3'b001 : (i == 1) ? 3'b101 : 3'b111;
      exp_sum = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      r1_drive(v[2], v[1], v[0], 1'b1);
      #1;
      chk("r1_hold", {if_r1.cout, if_r1.s}, prev);
      @(posedge clk); #1;
      chk("r1_b2b", {if_r1.out_valid, if_r1.cout, if_r1.s}, {1'b1, exp_sum});
      $display("r1 vec a=%0d b=%0d cin=%0d -> cout=%0d s=%0d", v[2], v[1], v[0], if_r1.cout, if_r1.s);
      prev = exp_sum;
    end

    // WIDTH=8 registered random stream, valid toggled randomly.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic       rc, riv;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      riv = 1'($urandom_range(0, 1));
      @(negedge clk);
      if_r8.a = ra; if_r8.b = rb; if_r8.cin = rc; if_r8.in_valid = riv;
      @(posedge clk); #1;
      model(8, 32'(ra), 32'(rb), rc, es, ec, eo);
      chk("r8_sum", {if_r8.cout, if_r8.s}, {ec, es[7:0]});
      chk("r8_pg", {if_r8.p, if_r8.g}, {ra ^ rb, ra & rb});
      chk("r8_ovf_valid", {if_r8.ovf, if_r8.out_valid}, {eo, riv});
      $display("r8 a=%0h b=%0h cin=%0d v=%0d -> cout=%0d s=%0h", ra, rb, rc, riv, if_r8.cout, if_r8.s);
    end

    // Reset on the same edge as a valid 1+1+1: discarded.
    @(negedge clk);
    rst = 1'b1;
    r1_drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("r1_rst_prio", {if_r1.out_valid, if_r1.ovf, if_r1.g, if_r1.p, if_r1.cout, if_r1.s}, 6'b0);
    // After release, data loads even with in_valid low.
    @(negedge clk);
    rst = 1'b0;
    r1_drive(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("r1_invalid_load", {if_r1.out_valid, if_r1.cout, if_r1.s, if_r1.p}, 4'b0011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
